apple_field: RTL

Multi-apple manager for the snake LED matrix, replacing per-cell fixed-apple LEDs. Holds NUM_APPLES apple slots. Places each apple at a pseudo-random free cell, detects when the snake head eats one on a game tick, and respawns it after a programmable delay. Drives the red-LED plane through a scan-coordinate lookup and reports eats to the score and length logic.

---
 rtl/apple_pkg.sv | 15 +
 rtl/apple_lfsr.sv | 22 ++
 rtl/apple_field.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/apple_pkg.sv
// apple_pkg: shared types and constants for the apple field.
// Slot states and LFSR polynomial/seed live here.
package apple_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    WAIT
  } slot_state_t;

  localparam int          LFSR_W       = 16;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/apple_lfsr.sv
// apple_lfsr: 16-bit Galois LFSR with enable.
// Supplies candidate apple coordinates.
module apple_lfsr
  import apple_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/apple_field.sv
// apple_field: multi-apple placement, eat detection and respawn
// for the snake LED matrix red plane.
module apple_field
  import apple_pkg::*;
#(
  parameter int NUM_APPLES    = 4,
  parameter int COORD_W       = 5,
  parameter int GRID_W        = 16,
  parameter int GRID_H        = 16,
  parameter int RESPAWN_TICKS = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEFAULT_SEED,
  localparam int IDX_W = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          game_over,
  input  logic [COORD_W-1:0]            head_x,
  input  logic [COORD_W-1:0]            head_y,
  input  logic [COORD_W-1:0]            scan_x,
  input  logic [COORD_W-1:0]            scan_y,
  output logic                          light_on,
  output logic [NUM_APPLES-1:0]         apple_valid,
  output logic [NUM_APPLES*COORD_W-1:0] apples_x,
  output logic [NUM_APPLES*COORD_W-1:0] apples_y,
  output logic                          eat_pulse,
  output logic [IDX_W-1:0]              eat_idx,
  output logic [15:0]                   score
);

  localparam int CNT_W =
    (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
  localparam logic [NUM_APPLES-1:0] LSB = NUM_APPLES'(1);

  logic [LFSR_W-1:0]     lfsr;
  logic [COORD_W-1:0]    cx;
  logic [COORD_W-1:0]    cy;
  logic [NUM_APPLES-1:0] empty;
  logic [NUM_APPLES-1:0] hit;
  logic [NUM_APPLES-1:0] clash;
  logic [NUM_APPLES-1:0] shown;
  logic [NUM_APPLES-1:0] place_oh;
  logic [NUM_APPLES-1:0] eat_oh;
  logic [IDX_W-1:0]      eat_sel;
  logic                  play_tick;
  logic                  cand_ok;
  logic                  can_place;

  apple_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (!game_over),
    .value (lfsr)
  );

  assign cx = lfsr[COORD_W-1:0];
  assign cy = lfsr[2*COORD_W-1:COORD_W];

  assign play_tick = tick && !game_over;

  // Occupancy is judged on pre-edge ACTIVE coords only.
  assign cand_ok = (int'(cx) < GRID_W)
                && (int'(cy) < GRID_H)
                && !(cx == head_x && cy == head_y)
                && (clash == '0);

  assign can_place = cand_ok && !game_over;

  // Lowest set bit wins for both placement and eating.
  assign place_oh = can_place ? (empty & (~empty + LSB)) : '0;
  assign eat_oh   = play_tick ? (hit & (~hit + LSB)) : '0;

  always_comb begin
    eat_sel = '0;
    for (int i = 0; i < NUM_APPLES; i++) begin
      if (eat_oh[i]) eat_sel = IDX_W'(i);
    end
  end

  assign light_on = !game_over && (shown != '0);

  for (genvar g = 0; g < NUM_APPLES; g++) begin : g_slot
    slot_state_t        st;
    slot_state_t        st_n;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               act;

    assign act            = (st == ACTIVE);
    assign empty[g]       = (st == EMPTY);
    assign hit[g]         = act && x == head_x && y == head_y;
    assign clash[g]       = act && x == cx && y == cy;
    assign shown[g]       = act && x == scan_x && y == scan_y;
    assign apple_valid[g] = act;
    assign apples_x[g*COORD_W +: COORD_W] = x;
    assign apples_y[g*COORD_W +: COORD_W] = y;

    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      unique case (st)
        EMPTY: begin
          if (place_oh[g]) st_n = ACTIVE;
        end
        ACTIVE: begin
          if (eat_oh[g]) begin
            if (RESPAWN_TICKS == 0) begin
              st_n = EMPTY;
            end else begin
              st_n  = WAIT;
              cnt_n = CNT_W'(RESPAWN_TICKS - 1);
            end
          end
        end
        WAIT: begin
          if (play_tick) begin
            if (cnt == '0) st_n = EMPTY;
            else           cnt_n = cnt - CNT_W'(1);
          end
        end
        default: st_n = EMPTY;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st  <= EMPTY;
        x   <= '0;
        y   <= '0;
        cnt <= '0;
      end else begin
        st  <= st_n;
        cnt <= cnt_n;
        if (place_oh[g]) begin
          x <= cx;
          y <= cy;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eat_pulse <= 1'b0;
      eat_idx   <= '0;
      score     <= '0;
    end else begin
      eat_pulse <= (eat_oh != '0);
      if (eat_oh != '0) begin
        eat_idx <= eat_sel;
        if (score != 16'hFFFF) score <= score + 16'd1;
      end
    end
  end

endmodule
